pc_ctrl: RTL
============

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter XLEN, default 32, datapath/address width.
REQ-002 Parameter RESET_VECTOR, default 0, PC value after reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100, PC loaded on misaligned-target trap.
REQ-004 Parameter CNT_W, default 16, width of update counter.
REQ-005 The clock SHALL be i_clk; reset SHALL be i_arst_n, asynchronous, active-low (one clock domain only).
REQ-006 i_clk  in  1  clock; i_arst_n  in  1  async active-low reset.
REQ-007 i_pcWrite  in  1  multi-cycle PC update enable.
REQ-008 i_pcSrc  in  2  next-PC select: 00 seq (pc+4), 01 target, 10 return (epc), 11 jalr (target with bit0 cleared).
REQ-009 i_target  in  XLEN  branch/jump target address.
REQ-010 i_halt  in  1  halt request; i_resume  in  1  resume request.
REQ-011 o_pc  out  XLEN  current PC; o_oldPc  out  XLEN  PC before last update.
REQ-012 o_epc  out  XLEN  PC of trapping instruction; o_badAddr  out  XLEN  offending target.
REQ-013 o_misaligned  out  1  trap pulse; o_halted  out  1  HALT state flag; o_updCnt  out  CNT_W  accepted-update count.

Function
REQ-014 States RUN, TRAP, HALT SHALL be implemented; all outputs registered.
REQ-015 Candidate SHALL be per i_pcSrc; pc+4 SHALL wrap modulo 2^XLEN.
REQ-016 In RUN with i_pcWrite=1, i_halt=0 and candidate[1:0]==0: next cycle pc=candidate, oldPc=previous pc, updCnt+1 (wraps modulo 2^CNT_W).
REQ-017 In RUN with i_pcWrite=1, i_halt=0 and candidate[1:0]!=0: next cycle pc=TRAP_VECTOR, oldPc=previous pc, epc=previous pc, badAddr=candidate, state=TRAP; updCnt unchanged.
REQ-018 o_misaligned SHALL be 1 exactly while state==TRAP (one cycle).
REQ-019 TRAP SHALL last one cycle, ignore i_pcWrite and i_halt, then go to RUN.
REQ-020 In RUN, i_halt=1 SHALL take priority over i_pcWrite: update discarded, state=HALT next cycle.
REQ-021 In HALT, pc/oldPc/epc/badAddr/updCnt SHALL hold; i_resume=1 with i_halt=0 SHALL return to RUN next cycle; i_resume=1 with i_halt=1 SHALL stay HALT.
REQ-022 i_resume outside HALT SHALL be ignored.
REQ-023 o_halted SHALL equal (state==HALT).
REQ-024 In RUN with i_pcWrite=0 and i_halt=0, all state SHALL hold.
REQ-025 pcSrc=10 SHALL use current o_epc; misalignment check applies identically.

Reset
REQ-026 Assertion of i_arst_n=0 SHALL immediately (asynchronously) force pc=RESET_VECTOR, oldPc=RESET_VECTOR, epc=0, badAddr=0, updCnt=0, state=RUN, o_misaligned=0, o_halted=0, including mid-TRAP or mid-HALT.
REQ-027 Release SHALL be synchronous to i_clk; first update possible on first edge after release.
REQ-028 Elaboration SHALL fail if RESET_VECTOR[1:0] or TRAP_VECTOR[1:0] is non-zero.

Structure
REQ-029 Package pc_pkg SHALL hold the state enum and the pcSrc encoding enum.
REQ-030 Single flat module; no sub-module is warranted.

Verification
REQ-031 Reset, then pcWrite=1, pcSrc=00 for 3 cycles -> pc 0,4,8,C; oldPc 8 after third; updCnt=3.
REQ-032 pc=0x40, pcSrc=01, target=0x1002 -> pc=0x100, epc=0x40, badAddr=0x1002, o_misaligned high one cycle, updCnt unchanged; then pcSrc=10 -> pc=0x40.
REQ-033 pcSrc=11, target=0x205 -> pc=0x204 (bit0 cleared, aligned); target=0x207 -> trap, badAddr=0x206.
REQ-034 pc=0x10, halt=1 with pcWrite=1 -> pc stays 0x10, o_halted=1; halt=1,resume=1 -> stays HALT; resume=1 alone -> RUN next cycle.
REQ-035 XLEN=32, pc=0xFFFF_FFFC, pcSrc=00 -> pc=0; CNT_W=4, 16 updates -> updCnt=0.
REQ-036 Assert i_arst_n=0 mid-TRAP between edges -> outputs at reset values before next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program-counter controller: FSM states and the
// next-PC source encoding driven by the decode stage.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_TRAP = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'b00,
    SRC_TARGET = 2'b01,
    SRC_RETURN = 2'b10,
    SRC_JALR   = 2'b11
  } pc_src_e;

endpackage

// File: rtl/pc_ctrl.sv
// Program-counter controller: sequential/branch/return/jalr updates, a one-cycle
// trap on misaligned targets, and a halt/resume handshake. All outputs registered.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_pcWrite,
  input  logic [1:0]       i_pcSrc,
  input  logic [XLEN-1:0]  i_target,
  input  logic             i_halt,
  input  logic             i_resume,
  output logic [XLEN-1:0]  o_pc,
  output logic [XLEN-1:0]  o_oldPc,
  output logic [XLEN-1:0]  o_epc,
  output logic [XLEN-1:0]  o_badAddr,
  output logic             o_misaligned,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_updCnt
);

  // Both vectors are loaded straight into the PC, so they must be word aligned.
  if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
    $error("pc_ctrl: RESET_VECTOR must be 4-byte aligned");
  end
  if (TRAP_VECTOR[1:0] != 2'b00) begin : g_bad_trap_vector
    $error("pc_ctrl: TRAP_VECTOR must be 4-byte aligned");
  end

  state_e            state, state_nxt;
  logic [XLEN-1:0]   cand;
  logic [XLEN-1:0]   pc_nxt, old_nxt, epc_nxt, bad_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  always_comb begin
    // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned and infers a latch.
    cand = o_pc + XLEN'(4);
    case (pc_src_e'(i_pcSrc))
      SRC_SEQ:    cand = o_pc + XLEN'(4);
      SRC_TARGET: cand = i_target;
      SRC_RETURN: cand = o_epc;
      SRC_JALR:   cand = {i_target[XLEN-1:1], 1'b0};
      default:    cand = o_pc + XLEN'(4);
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = o_pc;
    old_nxt   = o_oldPc;
    epc_nxt   = o_epc;
    bad_nxt   = o_badAddr;
    cnt_nxt   = o_updCnt;
    case (state)
      ST_RUN: begin
        // Halt wins over a pending update; the update is simply dropped.
        if (i_halt) begin
          state_nxt = ST_HALT;
        end else if (i_pcWrite) begin
          old_nxt = o_pc;
          if (cand[1:0] == 2'b00) begin
            pc_nxt  = cand;
            cnt_nxt = o_updCnt + CNT_W'(1);
          end else begin
            pc_nxt    = TRAP_VECTOR;
            epc_nxt   = o_pc;
            bad_nxt   = cand;
            state_nxt = ST_TRAP;
          end
        end
      end
      ST_TRAP: state_nxt = ST_RUN;
      ST_HALT: begin
        if (i_resume && !i_halt) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state        <= ST_RUN;
      o_pc         <= RESET_VECTOR;
      o_oldPc      <= RESET_VECTOR;
      o_epc        <= '0;
      o_badAddr    <= '0;
      o_updCnt     <= '0;
      o_misaligned <= 1'b0;
      o_halted     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state        <= state_nxt;
      o_pc         <= pc_nxt;
      o_oldPc      <= old_nxt;
      o_epc        <= epc_nxt;
      o_badAddr    <= bad_nxt;
      o_updCnt     <= cnt_nxt;
      o_misaligned <= (state_nxt == ST_TRAP);
      o_halted     <= (state_nxt == ST_HALT);
    end
  end

endmodule
